// File: rtl/lsu_mem_port.sv
// Purpose: load/store unit driving a word-addressed request/grant/response memory bus.
// Latency: store with immediate grant completes 2 cycles after accept; load with gnt at +1 and rvalid at +2 completes at +3.
// Backpressure: stall_o holds the pipeline from accept until the single-cycle done_o pulse; a missing gnt/rvalid aborts after TIMEOUT cycles.
module lsu_mem_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic              mem_wren_i,
    input  logic [3:0]        mem_wrnum_i,
    input  logic              mem_us_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    output logic [31:0]       ld_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic              stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last counter value before the wait is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic [3:0]        mask_q, mask_d;
    logic              us_q, us_d;
    logic              err_q, err_d;
    logic [31:0]       ld_q, ld_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              pre_err;
    logic              mask_legal;
    logic [1:0]        off;
    logic [3:0]        be_full;
    logic [31:0]       lane_mask;
    logic [31:0]       wdata_full;
    logic [31:0]       rshift;
    logic [31:0]       ld_ext;
    logic              in_req;
    logic              timeout_hit;

    // Alignment and mask legality of the incoming request, evaluated in the accept cycle.
    always_comb begin
        mask_legal = 1'b0;
        pre_err    = 1'b0;
        case (mem_wrnum_i)
            4'b0000, 4'b0001: mask_legal = 1'b1;
            4'b0011: begin
                mask_legal = 1'b1;
                pre_err    = addr_i[0];
            end
            4'b1111: begin
                mask_legal = 1'b1;
                pre_err    = (addr_i[1:0] != 2'b00);
            end
            default: mask_legal = 1'b0;
        endcase
        if (!mask_legal) begin
            pre_err = 1'b1;
        end
    end

    // Lane placement of store data and extraction of load data, both from the latched request.
    always_comb begin
        off        = addr_q[1:0];
        be_full    = mask_q << off;
        lane_mask  = {{8{be_full[3]}}, {8{be_full[2]}}, {8{be_full[1]}}, {8{be_full[0]}}};
        wdata_full = (data_q << {off, 3'b000}) & lane_mask;
        rshift     = bus_rdata_i >> {off, 3'b000};
        case (mask_q)
            4'b0001: ld_ext = us_q ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
            4'b0011: ld_ext = us_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            default: ld_ext = rshift;
        endcase
    end

    assign in_req      = (state_q == S_REQ);
    assign timeout_hit = (cnt_q == TO_LAST);

    // Next-state logic: request latching, bus handshake, timeout abort and load capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = wren_q;
        mask_d  = mask_q;
        us_d    = us_q;
        err_d   = err_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (req_i) begin
                    addr_d = addr_i;
                    data_d = st_data_i;
                    wren_d = mem_wren_i;
                    mask_d = mem_wrnum_i;
                    us_d   = mem_us_i;
                    err_d  = 1'b0;
                    if (pre_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        if (!mem_wren_i) begin
                            ld_d = 32'd0;
                        end
                    end else if (mem_wrnum_i == 4'b0000) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    cnt_d = 8'd0;
                    if (wren_q) begin
                        state_d = S_DONE;
                    end else if (bus_rvalid_i) begin
                        ld_d    = ld_ext;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                    if (!wren_q) begin
                        ld_d = 32'd0;
                    end
                end
            end
            S_RESP: begin
                if (bus_rvalid_i) begin
                    ld_d    = ld_ext;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    ld_d    = 32'd0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= 32'd0;
            wren_q  <= 1'b0;
            mask_q  <= 4'd0;
            us_q    <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            mask_q  <= mask_d;
            us_q    <= us_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus outputs are only live while the request is being presented.
    assign bus_req_o   = in_req;
    assign bus_we_o    = in_req & wren_q;
    assign bus_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be_o    = in_req ? be_full : 4'd0;
    assign bus_wdata_o = in_req ? wdata_full : 32'd0;
    assign ld_data_o   = ld_q;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_DONE) & err_q;

    // Stall follows the request in IDLE, holds during the bus access and releases in DONE.
    always_comb begin
        case (state_q)
            S_IDLE:        stall_o = req_i & rst_ni;
            S_REQ, S_RESP: stall_o = 1'b1;
            default:       stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Purpose: self-checking bench for lsu_mem_port: directed vector table, randomized accesses vs. a behavioural model, reset-abort sequence.
// Latency: each access is bounded by a fixed cycle budget; a missing done_o shows up as a wrong completion cycle.
// Backpressure: the bench plays the bus, granting after a programmed number of request cycles and returning rvalid a programmed delay after grant.
module tb_lsu_mem_port;

    localparam int TO    = 4;
    localparam int LIMIT = 20;
    localparam int NEVER = 99;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        mem_wren_i = 1'b0;
    logic [3:0]  mem_wrnum_i = '0;
    logic        mem_us_i = 1'b0;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic [31:0] ld_data_o;
    logic        done_o, err_o, stall_o;

    int tests  = 0;
    int failed = 0;

    lsu_mem_port #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
        .st_data_i(st_data_i), .mem_wren_i(mem_wren_i), .mem_wrnum_i(mem_wrnum_i),
        .mem_us_i(mem_us_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .ld_data_o(ld_data_o), .done_o(done_o), .err_o(err_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wren;
        logic [3:0]  mask;
        logic        us;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [31:0] ld;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        int          req_cycles;
        int          pulses;
        logic        stall_ok;
    } obs_t;

    typedef struct {
        vec_t v;
        obs_t e;
    } tv_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic tv_t mk(input logic [31:0] addr, input logic [31:0] data, input logic wren,
                               input logic [3:0] mask, input logic us, input int g, input int rv,
                               input logic [31:0] rdata, input int done_cyc, input logic err,
                               input logic [31:0] ld, input logic [3:0] be, input logic [31:0] wdata,
                               input logic [31:0] eaddr, input int reqc);
        tv_t t;
        t.v = '{addr, data, wren, mask, us, g, rv, rdata};
        t.e = '{done_cyc, err, ld, be, wdata, eaddr, wren, reqc, 1, 1'b1};
        return t;
    endfunction

    // Behavioural expectation of one access from the architectural rules.
    function automatic obs_t model(input vec_t v, input logic [31:0] ld_prev);
        obs_t e;
        int off;
        logic bad;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ext;
        off = int'(v.addr[1:0]);
        bad = !(v.mask inside {4'b0000, 4'b0001, 4'b0011, 4'b1111}) ||
              (v.mask == 4'b0011 && v.addr[0]) || (v.mask == 4'b1111 && off != 0);
        e = '{0, 1'b0, ld_prev, 4'd0, 32'd0, {v.addr[31:2], 2'b00}, v.wren, 0, 1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i] && i + off < 4) begin
                e.be[i+off] = 1'b1;
                e.wdata[8*(i+off) +: 8] = v.data[8*i +: 8];
            end
        end
        b = v.rdata[8*off +: 8];
        h = (off < 3) ? v.rdata[8*off +: 16] : 16'd0;
        case (v.mask)
            4'b0001: ext = v.us ? {24'd0, b} : {{24{b[7]}}, b};
            4'b0011: ext = v.us ? {16'd0, h} : {{16{h[15]}}, h};
            default: ext = v.rdata;
        endcase
        if (bad) begin
            e.done_cyc = 1; e.err = 1'b1;
            if (!v.wren) e.ld = 32'd0;
        end else if (v.mask == 4'b0000) begin
            e.done_cyc = 1;
        end else if (v.gnt_dly >= TO) begin
            e.done_cyc = 1 + TO; e.err = 1'b1; e.req_cycles = TO;
            if (!v.wren) e.ld = 32'd0;
        end else begin
            e.req_cycles = v.gnt_dly + 1;
            if (v.wren) begin
                e.done_cyc = 2 + v.gnt_dly;
            end else if (v.rv_dly <= TO) begin
                e.done_cyc = 2 + v.gnt_dly + v.rv_dly;
                e.ld = ext;
            end else begin
                e.done_cyc = 2 + v.gnt_dly + TO;
                e.err = 1'b1;
                e.ld = 32'd0;
            end
        end
        return e;
    endfunction

    // Present one request and act as the bus; record what the DUT did.
    task automatic do_access(input vec_t v, output obs_t o);
        int req_seen = 0;
        int gcyc = -1;
        o = '{-1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1};
        @(posedge clk_i); #1;
        req_i = 1'b1; addr_i = v.addr; st_data_i = v.data; mem_wren_i = v.wren;
        mem_wrnum_i = v.mask; mem_us_i = v.us; bus_rdata_i = v.rdata;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        @(negedge clk_i);
        if (!stall_o || done_o) o.stall_ok = 1'b0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            @(posedge clk_i); #1;
            req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
            if (bus_req_o) begin
                if (req_seen == v.gnt_dly) begin
                    bus_gnt_i = 1'b1;
                    gcyc = cyc;
                end
                req_seen++;
            end
            if (gcyc >= 0 && !v.wren && cyc == gcyc + v.rv_dly) bus_rvalid_i = 1'b1;
            @(negedge clk_i);
            if (bus_req_o) begin
                o.req_cycles++;
                if (o.req_cycles == 1) begin
                    o.be = bus_be_o; o.wdata = bus_wdata_o; o.addr = bus_addr_o; o.we = bus_we_o;
                end
            end
            if (done_o) begin
                o.pulses++;
                if (stall_o) o.stall_ok = 1'b0;
                if (o.done_cyc < 0) begin
                    o.done_cyc = cyc;
                    o.err = err_o;
                end
            end else if (o.done_cyc < 0 && !stall_o) begin
                o.stall_ok = 1'b0;
            end
            if (o.done_cyc >= 0 && cyc > o.done_cyc) break;
        end
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        o.ld = ld_data_o;
    endtask

    task automatic check_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, " done_cycle"}, a.done_cyc, e.done_cyc);
        chk({tag, " err"}, {31'd0, a.err}, {31'd0, e.err});
        chk({tag, " ld_data"}, a.ld, e.ld);
        chk({tag, " done_pulses"}, a.pulses, e.pulses);
        chk({tag, " stall"}, {31'd0, a.stall_ok}, {31'd0, e.stall_ok});
        chk({tag, " req_cycles"}, a.req_cycles, e.req_cycles);
        if (e.req_cycles > 0) begin
            chk({tag, " be"}, {28'd0, a.be}, {28'd0, e.be});
            chk({tag, " bus_addr"}, a.addr, e.addr);
            chk({tag, " we"}, {31'd0, a.we}, {31'd0, e.we});
            if (e.we) chk({tag, " wdata"}, a.wdata, e.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv_t   tab [14];
        obs_t  o, e;
        vec_t  v;
        logic [31:0] ld_model;

        // Directed vectors with hand-derived expectations (TIMEOUT = 4).
        tab[0]  = mk(32'h1003, 32'h000000A5, 1, 4'b0001, 0, 0, 0, 32'h0, 2, 0, 32'h0, 4'b1000, 32'hA5000000, 32'h1000, 1);
        tab[1]  = mk(32'h2001, 32'h0, 0, 4'b0001, 0, 0, 1, 32'h0000F000, 3, 0, 32'hFFFFFFF0, 4'b0010, 32'h0, 32'h2000, 1);
        tab[2]  = mk(32'h2001, 32'h0, 0, 4'b0001, 1, 0, 1, 32'h0000F000, 3, 0, 32'h000000F0, 4'b0010, 32'h0, 32'h2000, 1);
        tab[3]  = mk(32'h2002, 32'h0, 0, 4'b0011, 0, 3, 2, 32'h80010000, 7, 0, 32'hFFFF8001, 4'b1100, 32'h0, 32'h2000, 4);
        tab[4]  = mk(32'h0005, 32'h0, 0, 4'b0000, 0, 0, 0, 32'h0, 1, 0, 32'hFFFF8001, 4'b0000, 32'h0, 32'h0, 0);
        tab[5]  = mk(32'h3002, 32'h0, 0, 4'b1111, 0, 0, 0, 32'h0, 1, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        tab[6]  = mk(32'h0000, 32'h0, 0, 4'b0101, 0, 0, 0, 32'h0, 1, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        tab[7]  = mk(32'h0010, 32'h0, 0, 4'b1111, 0, 1, 0, 32'h12345678, 3, 0, 32'h12345678, 4'b1111, 32'h0, 32'h10, 2);
        tab[8]  = mk(32'h0020, 32'h0, 0, 4'b1111, 0, 0, NEVER, 32'hAAAA5555, 6, 1, 32'h0, 4'b1111, 32'h0, 32'h20, 1);
        tab[9]  = mk(32'h0002, 32'h0000BEEF, 1, 4'b0011, 0, 1, 0, 32'h0, 3, 0, 32'h0, 4'b1100, 32'hBEEF0000, 32'h0, 2);
        tab[10] = mk(32'h0041, 32'hDEADBE77, 1, 4'b0001, 0, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0010, 32'h00007700, 32'h40, 1);
        tab[11] = mk(32'h0050, 32'h0, 0, 4'b0011, 1, 0, 1, 32'h1234F00D, 3, 0, 32'h0000F00D, 4'b0011, 32'h0, 32'h50, 1);
        tab[12] = mk(32'h0060, 32'h01020304, 1, 4'b1111, 0, 5, 0, 32'h0, 5, 1, 32'h0000F00D, 4'b1111, 32'h01020304, 32'h60, 4);
        tab[13] = mk(32'h0001, 32'h0, 0, 4'b0011, 0, 0, 0, 32'h0, 1, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);

        // Outputs under reset.
        #3;
        chk("reset_ctrl", {26'd0, bus_req_o, bus_we_o, done_o, err_o, stall_o, 1'b0},
            32'd0);
        chk("reset_bus", {28'd0, bus_be_o} | bus_wdata_o | bus_addr_o, 32'd0);
        chk("reset_ld", ld_data_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_access(tab[i].v, o);
            check_obs($sformatf("vec%0d", i), o, tab[i].e);
        end
        ld_model = 32'h0;

        // Randomized accesses against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            v.addr = $urandom & 32'h0000FFFF;
            v.data = $urandom;
            v.wren = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: v.mask = 4'b0001;
                1: v.mask = 4'b0011;
                2: v.mask = 4'b1111;
                3: v.mask = 4'b0000;
                default: v.mask = 4'($urandom);
            endcase
            if ($urandom_range(0, 2) != 0) begin
                if (v.mask == 4'b0011) v.addr[0] = 1'b0;
                if (v.mask == 4'b1111) v.addr[1:0] = 2'b00;
            end
            v.us = 1'($urandom_range(0, 1));
            v.gnt_dly = $urandom_range(0, 5);
            v.rv_dly = $urandom_range(0, 5);
            if (v.rv_dly == 5) v.rv_dly = NEVER;
            v.rdata = $urandom;
            e = model(v, ld_model);
            do_access(v, o);
            check_obs($sformatf("rnd%0d", i), o, e);
            ld_model = e.ld;
        end

        // Known load so the reset has a nonzero ld_data_o to clear.
        v = '{32'h70, 32'h0, 1'b0, 4'b1111, 1'b0, 0, 0, 32'hCAFEBABE};
        e = model(v, ld_model);
        do_access(v, o);
        check_obs("pre_reset_lw", o, e);

        // Reset while a load is waiting in RESP.
        @(posedge clk_i); #1;
        req_i = 1'b1; addr_i = 32'h80; mem_wren_i = 1'b0; mem_wrnum_i = 4'b1111; mem_us_i = 1'b0;
        @(posedge clk_i); #1;
        req_i = 1'b0; bus_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("resp_stall", {30'd0, stall_o, bus_req_o}, 32'd2);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_ctrl", {27'd0, bus_req_o, bus_we_o, done_o, err_o, stall_o}, 32'd0);
        chk("midrst_bus", {28'd0, bus_be_o} | bus_wdata_o | bus_addr_o, 32'd0);
        chk("midrst_ld", ld_data_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        begin
            int spurious = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk_i);
                if (done_o || err_o || bus_req_o) spurious++;
            end
            chk("post_reset_quiet", spurious, 0);
        end
        v = '{32'h0, 32'h11223344, 1'b1, 4'b1111, 1'b0, 0, 0, 32'h0};
        e = model(v, 32'h0);
        do_access(v, o);
        check_obs("post_reset_sw", o, e);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
